boreal_bus_arbiter: RTL and testbench
=====================================

Name: boreal_bus_arbiter

Overview:
- Two-master arbiter and transaction sequencer in front of the boreal interconnect address decoder.
- Shares the single slave-side bus between the public master and the gate master.
- Gate has strict priority. Holds the grant and address stable until the slave responds.
- Rejects public accesses to the PRIV region (addr[31:28]==4'h2) locally. Aborts hung transactions with a watchdog.

Parameters:
- ADDR_W, 32, address width for all address ports.
- TIMEOUT_CYC, 256, cycles in a bus state without slave response before abort; legal range 2..65536.
- STARVE_LIMIT, 8, consecutive gate grants with public pending before public is forced (fairness build only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pub_req  in  1  public master request; held until pub_ack/pub_err
- pub_addr  in  ADDR_W  public master address
- pub_ack  out  1  public transaction complete
- pub_err  out  1  public transaction failed (PRIV violation, slave error, timeout)
- gate_req  in  1  gate master request; held until gate_ack/gate_err
- gate_addr  in  ADDR_W  gate master address
- gate_ack  out  1  gate transaction complete
- gate_err  out  1  gate transaction failed
- arb_req  out  1  request to decoder/slaves
- arb_addr  out  ADDR_W  registered address of the active transaction
- arb_is_gate  out  1  active transaction owned by gate
- slv_ack  in  1  slave response OK
- slv_err  in  1  slave response error
- timeout_irq  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including arb_addr. Timeout counter 0. Starve counter 0.
- States: IDLE, BUS_PUB, BUS_GATE, RESP.
- IDLE, transitions in priority order:
  - gate_req → BUS_GATE; latch gate_addr.
  - else pub_req with pub_addr[31:28]==4'h2 → RESP with err, owner=pub; arb_req never asserted.
  - else pub_req → BUS_PUB; latch pub_addr.
  - Else stay in IDLE.
- BUS_*:
  - arb_req=1. arb_addr stable. arb_is_gate=1 only in BUS_GATE.
  - Master address inputs are ignored after latch.
  - slv_err → RESP with err. slv_ack alone → RESP with ack. Both high: err wins.
  - Timeout counter increments each cycle spent in BUS_*. On reaching TIMEOUT_CYC-1 with no response → RESP with err, and timeout_irq=1 in that RESP cycle.
- RESP:
  - Exactly one cycle. arb_req=0.
  - The owner's ack or err is 1; the other master's ack/err is 0.
  - Next state IDLE. Timeout counter cleared.
- Latency:
  - Request to arb_req: 1 cycle.
  - Slave response to master ack/err: 1 cycle.
  - Minimum transaction: 3 cycles IDLE→BUS→RESP.
  - PRIV rejection: 1 cycle to pub_err.
- Master rule: drop req in the cycle after ack/err. A req still high in IDLE is a new transaction.
- slv_ack/slv_err outside BUS_* are ignored.
- Invariants:
  - arb_req==0 whenever both reqs have been low for 2 cycles.
  - ack and err never both high.
  - pub_* and gate_* responses never both high.

Optional Feature:
- Macro BOREAL_ARB_FAIRNESS_EN.
- When defined:
  - Starve counter increments on each IDLE→BUS_GATE taken while pub_req=1. It saturates at STARVE_LIMIT.
  - In IDLE with counter==STARVE_LIMIT and pub_req=1, public is served (BUS_PUB or PRIV reject) even if gate_req=1.
  - Counter clears on any public grant/reject.
- When undefined: strict gate priority. No counter is instantiated.

Decomposition:
- boreal_pkg:
  - State encodings ARB_IDLE/ARB_BUS_PUB/ARB_BUS_GATE/ARB_RESP (2-bit).
  - REGION_PRIV = 4'h2.
  - ARB_TIMEOUT_DEFAULT = 256.
- Sub-module boreal_arb_watchdog: clear/enable counter, width $clog2(TIMEOUT_CYC), outputs expire.

Test Plan:
- Single public read of 0x1000_0040, slave acks 2 cycles after arb_req → arb_req cycles 1–3, arb_is_gate=0, pub_ack pulse cycle 4, gate_* stay 0.
- pub_req and gate_req rise together (addrs 0x1000_0000/0x3000_0000) → gate served first (arb_addr=0x3000_0000, arb_is_gate=1); public follows after RESP+IDLE.
- Public to 0x2000_0010 → pub_err one cycle after request, arb_req never asserts, timeout_irq=0.
- Gate to 0x4000_0000 with slave silent, TIMEOUT_CYC=16 → arb_req high 16 cycles, then gate_err and timeout_irq pulse together, then IDLE.
- slv_ack and slv_err high in the same cycle during BUS_PUB → pub_err=1, pub_ack=0.
- rst_n low mid-BUS_GATE → all outputs 0 immediately. After release, IDLE re-arbitrates. Fairness build, gate_req continuously high, STARVE_LIMIT=8 → 9th grant goes to public.

Source files
------------

// File: rtl/boreal_pkg.sv
// Shared encodings and constants for the boreal interconnect arbiter slice.
// Pure declarations; no timing or flow control of its own.
package boreal_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_BUS_PUB  = 2'd1,
        ARB_BUS_GATE = 2'd2,
        ARB_RESP     = 2'd3
    } arb_state_e;

    localparam logic [3:0] REGION_PRIV         = 4'h2;
    localparam int         ARB_TIMEOUT_DEFAULT = 256;

    function automatic logic is_priv_region(input logic [3:0] region);
        return region == REGION_PRIV;
    endfunction

endpackage

// File: rtl/boreal_arb_watchdog.sv
// Bus-phase watchdog: counts cycles while enabled, flags expiry combinationally.
// Expire is high in the TIMEOUT_CYC-th enabled cycle; clear has priority over enable.
module boreal_arb_watchdog #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/boreal_bus_arbiter.sv
// Two-master arbiter (gate strictly first) with PRIV filtering and bus watchdog; 1 cycle req->arb_req, 1 cycle slave->master.
// Masters hold req until ack/err; BOREAL_ARB_FAIRNESS_EN adds a starvation override for the public master.
module boreal_bus_arbiter
    import boreal_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_DEFAULT
`ifdef BOREAL_ARB_FAIRNESS_EN
    ,
    parameter int STARVE_LIMIT = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pub_req,
    input  logic [ADDR_W-1:0] pub_addr,
    output logic              pub_ack,
    output logic              pub_err,
    input  logic              gate_req,
    input  logic [ADDR_W-1:0] gate_addr,
    output logic              gate_ack,
    output logic              gate_err,
    output logic              arb_req,
    output logic [ADDR_W-1:0] arb_addr,
    output logic              arb_is_gate,
    input  logic              slv_ack,
    input  logic              slv_err,
    output logic              timeout_irq
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              owner_gate_q, owner_gate_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              in_bus, in_resp, wd_expire, pub_priv, pub_first, gate_win;

    assign in_bus   = (state_q == ARB_BUS_PUB) || (state_q == ARB_BUS_GATE);
    assign in_resp  = (state_q == ARB_RESP);
    assign pub_priv = is_priv_region(pub_addr[ADDR_W-1 -: 4]);
    assign gate_win = gate_req && !pub_first;

    boreal_arb_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!in_bus),
        .en_i     (in_bus),
        .expire_o (wd_expire)
    );

`ifdef BOREAL_ARB_FAIRNESS_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_q, starve_d;

    assign pub_first = pub_req && (starve_q == SW'(STARVE_LIMIT));

    // Only grants decided in IDLE move the counter; a public grant or reject resets it.
    always_comb begin
        starve_d = starve_q;
        if (state_q == ARB_IDLE) begin
            if (gate_win && pub_req && (starve_q != SW'(STARVE_LIMIT))) begin
                starve_d = starve_q + 1'b1;
            end else if (!gate_win && pub_req) begin
                starve_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign pub_first = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        owner_gate_d = owner_gate_q;
        err_d        = err_q;
        tmo_d        = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (gate_win) begin
                    state_d      = ARB_BUS_GATE;
                    addr_d       = gate_addr;
                    owner_gate_d = 1'b1;
                end else if (pub_req) begin
                    owner_gate_d = 1'b0;
                    if (pub_priv) begin
                        state_d = ARB_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ARB_BUS_PUB;
                        addr_d  = pub_addr;
                    end
                end
            end
            ARB_BUS_PUB, ARB_BUS_GATE: begin
                // A real slave response in the expiry cycle beats the timeout.
                if (slv_err || slv_ack) begin
                    state_d = ARB_RESP;
                    err_d   = slv_err;
                end else if (wd_expire) begin
                    state_d = ARB_RESP;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            addr_q       <= '0;
            owner_gate_q <= 1'b0;
            err_q        <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            owner_gate_q <= owner_gate_d;
            err_q        <= err_d;
            tmo_q        <= tmo_d;
        end
    end

    assign arb_req     = in_bus;
    assign arb_addr    = addr_q;
    assign arb_is_gate = (state_q == ARB_BUS_GATE);
    assign pub_ack     = in_resp && !owner_gate_q && !err_q;
    assign pub_err     = in_resp && !owner_gate_q &&  err_q;
    assign gate_ack    = in_resp &&  owner_gate_q && !err_q;
    assign gate_err    = in_resp &&  owner_gate_q &&  err_q;
    assign timeout_irq = tmo_q;

endmodule

// File: tb/tb_boreal_bus_arbiter.sv
// Directed bench for boreal_bus_arbiter with a transaction-level reference model.
module tb_boreal_bus_arbiter;

    localparam int TMO   = 16;
    localparam int LIMIT = 8;
`ifdef BOREAL_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pub_req = 1'b0, gate_req = 1'b0;
    logic [31:0] pub_addr = '0, gate_addr = '0;
    logic        slv_ack = 1'b0, slv_err = 1'b0;
    logic        pub_ack, pub_err, gate_ack, gate_err;
    logic        arb_req, arb_is_gate, timeout_irq;
    logic [31:0] arb_addr;

    int nchecks = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    boreal_bus_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .pub_req(pub_req), .pub_addr(pub_addr), .pub_ack(pub_ack), .pub_err(pub_err),
        .gate_req(gate_req), .gate_addr(gate_addr), .gate_ack(gate_ack), .gate_err(gate_err),
        .arb_req(arb_req), .arb_addr(arb_addr), .arb_is_gate(arb_is_gate),
        .slv_ack(slv_ack), .slv_err(slv_err), .timeout_irq(timeout_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one transaction record in flight, one pending response record.
    bit          m_busy = 0, m_gate = 0, m_resp = 0, m_resp_gate = 0, m_resp_err = 0, m_resp_tmo = 0;
    logic [31:0] m_addr = '0;
    int          m_age = 0, m_starve = 0;
    bit          m_pub_first;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_gate = 0; m_resp = 0; m_resp_gate = 0; m_resp_err = 0; m_resp_tmo = 0;
            m_addr = '0; m_age = 0; m_starve = 0;
        end else if (m_busy) begin
            if (slv_ack || slv_err || m_age == TMO - 1) begin
                m_busy      = 0;
                m_resp      = 1;
                m_resp_gate = m_gate;
                m_resp_err  = slv_err || !slv_ack;
                m_resp_tmo  = !slv_ack && !slv_err;
            end else begin
                m_age++;
            end
        end else if (m_resp) begin
            m_resp = 0;
        end else begin
            m_pub_first = pub_req && (!gate_req || (FAIR && m_starve == LIMIT));
            if (gate_req && !m_pub_first) begin
                m_busy = 1; m_gate = 1; m_addr = gate_addr; m_age = 0;
                if (FAIR && pub_req && m_starve < LIMIT) m_starve++;
            end else if (pub_req) begin
                m_starve = 0;
                if (pub_addr[31:28] == 4'h2) begin
                    m_resp = 1; m_resp_gate = 0; m_resp_err = 1; m_resp_tmo = 0;
                end else begin
                    m_busy = 1; m_gate = 0; m_addr = pub_addr; m_age = 0;
                end
            end
        end
    end

    // Cumulative event counters, read as before/after differences by the stimulus.
    int c_arb = 0, c_pub_ack = 0, c_pub_err = 0, c_gate_rsp = 0, c_irq = 0;

    always @(negedge clk) begin
        chk("arb_req", arb_req, m_busy);
        chk("arb_is_gate", arb_is_gate, m_busy && m_gate);
        if (m_busy) chk("arb_addr", arb_addr, m_addr);
        chk("pub_ack", pub_ack, m_resp && !m_resp_gate && !m_resp_err);
        chk("pub_err", pub_err, m_resp && !m_resp_gate && m_resp_err);
        chk("gate_ack", gate_ack, m_resp && m_resp_gate && !m_resp_err);
        chk("gate_err", gate_err, m_resp && m_resp_gate && m_resp_err);
        chk("timeout_irq", timeout_irq, m_resp && m_resp_tmo);
        chk("inv_ack_err", (pub_ack & pub_err) | (gate_ack & gate_err), 1'b0);
        chk("inv_pub_gate", (pub_ack | pub_err) & (gate_ack | gate_err), 1'b0);
        c_arb      += int'(arb_req);
        c_pub_ack  += int'(pub_ack);
        c_pub_err  += int'(pub_err);
        c_gate_rsp += int'(gate_ack | gate_err);
        c_irq      += int'(timeout_irq);
    end

    int s_arb, s_pub_ack, s_pub_err, s_gate_rsp, s_irq;

    task automatic snap();
        s_arb = c_arb; s_pub_ack = c_pub_ack; s_pub_err = c_pub_err;
        s_gate_rsp = c_gate_rsp; s_irq = c_irq;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  grants, first_pub;
        bit  prev_arb;

        // Reset state
        #3;
        chk("rst_arb_req", arb_req, 1'b0);
        chk("rst_arb_addr", arb_addr, 32'h0);
        chk("rst_pub_resp", {pub_ack, pub_err}, 2'b00);
        chk("rst_gate_resp", {gate_ack, gate_err, timeout_irq}, 3'b000);
        tick();
        rst_n = 1'b1;
        tick(); tick();

        // 1: single public access, slave acks two cycles after arb_req
        snap();
        pub_addr = 32'h1000_0040; pub_req = 1'b1;
        tick();
        chk("t1_arb_req_c1", arb_req, 1'b1);
        chk("t1_arb_addr", arb_addr, 32'h1000_0040);
        chk("t1_is_gate", arb_is_gate, 1'b0);
        tick();
        pub_addr = 32'hDEAD_BEEF;
        tick();
        chk("t1_addr_stable", arb_addr, 32'h1000_0040);
        slv_ack = 1'b1;
        tick();
        slv_ack = 1'b0;
        chk("t1_pub_ack_c4", pub_ack, 1'b1);
        chk("t1_arb_req_c4", arb_req, 1'b0);
        tick();
        pub_req = 1'b0;
        tick(); tick();
        chk("t1_arb_cycles", c_arb - s_arb, 3);
        chk("t1_pub_ack_cnt", c_pub_ack - s_pub_ack, 1);
        chk("t1_gate_quiet", c_gate_rsp - s_gate_rsp, 0);

        // 2: simultaneous requests, gate first
        pub_addr = 32'h1000_0000; gate_addr = 32'h3000_0000;
        pub_req = 1'b1; gate_req = 1'b1;
        tick();
        chk("t2_gate_addr", arb_addr, 32'h3000_0000);
        chk("t2_gate_owner", arb_is_gate, 1'b1);
        slv_ack = 1'b1;
        tick();
        slv_ack = 1'b0;
        chk("t2_gate_ack", gate_ack, 1'b1);
        tick();
        gate_req = 1'b0;
        chk("t2_idle_gap", arb_req, 1'b0);
        tick();
        chk("t2_pub_addr", arb_addr, 32'h1000_0000);
        chk("t2_pub_owner", {arb_req, arb_is_gate}, 2'b10);
        slv_ack = 1'b1;
        tick();
        slv_ack = 1'b0;
        chk("t2_pub_ack", pub_ack, 1'b1);
        tick();
        pub_req = 1'b0;
        tick(); tick();

        // 3: public access to PRIV region rejected locally
        snap();
        pub_addr = 32'h2000_0010; pub_req = 1'b1;
        tick();
        chk("t3_pub_err", pub_err, 1'b1);
        chk("t3_no_irq", timeout_irq, 1'b0);
        tick();
        pub_req = 1'b0;
        tick(); tick();
        chk("t3_no_arb_req", c_arb - s_arb, 0);

        // 4: gate access with a silent slave hits the watchdog
        snap();
        gate_addr = 32'h4000_0000; gate_req = 1'b1;
        for (int i = 0; i < TMO + 1; i++) tick();
        chk("t4_gate_err", gate_err, 1'b1);
        chk("t4_irq", timeout_irq, 1'b1);
        tick();
        gate_req = 1'b0;
        chk("t4_irq_pulse", timeout_irq, 1'b0);
        tick(); tick();
        chk("t4_arb_cycles", c_arb - s_arb, TMO);
        chk("t4_irq_cnt", c_irq - s_irq, 1);

        // 5: ack and err together, err wins
        pub_addr = 32'h1000_0080; pub_req = 1'b1;
        tick();
        slv_ack = 1'b1; slv_err = 1'b1;
        tick();
        slv_ack = 1'b0; slv_err = 1'b0;
        chk("t5_resp", {pub_ack, pub_err}, 2'b01);
        tick();
        pub_req = 1'b0;
        tick(); tick();

        // 6: reset asserted mid gate transaction
        gate_addr = 32'h5000_0000; gate_req = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_arb_req", arb_req, 1'b0);
        chk("t6_rst_arb_addr", arb_addr, 32'h0);
        chk("t6_rst_is_gate", arb_is_gate, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_rearb", {arb_req, arb_is_gate}, 2'b11);
        chk("t6_rearb_addr", arb_addr, 32'h5000_0000);
        slv_ack = 1'b1;
        tick();
        slv_ack = 1'b0;
        chk("t6_gate_ack", gate_ack, 1'b1);
        tick();
        gate_req = 1'b0;
        tick(); tick();

        // 7: both masters request continuously; count grants until public wins
        grants = 0; first_pub = 0; prev_arb = 1'b0;
        gate_addr = 32'h6000_0000; pub_addr = 32'h1000_0100;
        gate_req = 1'b1; pub_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (arb_req && !prev_arb) begin
                grants++;
                if (!arb_is_gate && first_pub == 0) first_pub = grants;
            end
            prev_arb = arb_req;
            slv_ack  = arb_req;
            if (first_pub != 0 || grants >= 12) break;
        end
        tick();
        slv_ack = 1'b0;
        tick();
        gate_req = 1'b0; pub_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        if (FAIR) chk("t7_first_pub_grant", first_pub, 9);
        else      chk("t7_strict_priority", {grants[7:0], first_pub[7:0]}, {8'd12, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
